// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands/control, selects ALU operand b,
// and inserts bubbles for load-use hazards, flush and invalid ID. Optional WB bypass: ID_EX_WB_BYPASS_EN.
module id_ex_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ID_EX_WB_BYPASS_EN
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
`endif
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_alu_src,
  input  logic [2:0]            id_alu_control,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_a,
  output logic [DATA_W-1:0]     ex_b,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [2:0]            ex_alu_control,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  load_use_stall
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     store_data;
    logic [2:0]            alu_control;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } slot_t;

  slot_t             slot_d, slot_q;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  // Operand source: register file read, or same-cycle WB write when bypass is built in.
  always_comb begin
    rs1_val = id_rs1_data;
    rs2_val = id_rs2_data;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) rs1_val = wb_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) rs2_val = wb_data;
`endif
  end

  assign load_use_stall = slot_q.valid & slot_q.mem_read & (slot_q.rd != '0) &
                          ((slot_q.rd == id_rs1) | (slot_q.rd == id_rs2)) & id_valid;

  // Priority: flush > stall (hold) > load-use / invalid bubble > capture.
  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d = '0;
    end else if (stall) begin
      slot_d = slot_q;
    end else if (load_use_stall || !id_valid) begin
      slot_d = '0;
    end else begin
      slot_d.valid       = 1'b1;
      slot_d.a           = rs1_val;
      slot_d.b           = id_alu_src ? id_imm : rs2_val;
      slot_d.store_data  = rs2_val;
      slot_d.alu_control = id_alu_control;
      slot_d.rs1         = id_rs1;
      slot_d.rs2         = id_rs2;
      slot_d.rd          = id_rd;
      slot_d.reg_write   = id_reg_write;
      slot_d.mem_read    = id_mem_read;
      slot_d.mem_write   = id_mem_write;
      slot_d.mem_to_reg  = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign ex_valid       = slot_q.valid;
  assign ex_a           = slot_q.a;
  assign ex_b           = slot_q.b;
  assign ex_store_data  = slot_q.store_data;
  assign ex_alu_control = slot_q.alu_control;
  assign ex_rs1         = slot_q.rs1;
  assign ex_rs2         = slot_q.rs2;
  assign ex_rd          = slot_q.rd;
  assign ex_reg_write   = slot_q.reg_write;
  assign ex_mem_read    = slot_q.mem_read;
  assign ex_mem_write   = slot_q.mem_write;
  assign ex_mem_to_reg  = slot_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Table-driven bench for id_ex_reg, plus hand sequences for async reset and WB bypass.
module tb_id_ex_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk, rst_n, stall, flush, id_valid;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic          id_alu_src;
  logic [2:0]    id_alu_control;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          ex_valid;
  logic [DW-1:0] ex_a, ex_b, ex_store_data;
  logic [2:0]    ex_alu_control;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          load_use_stall;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  id_ex_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ID_EX_WB_BYPASS_EN
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_alu_control(ex_alu_control), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .load_use_stall(load_use_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          stall, flush, valid;
    logic [DW-1:0] rs1d, rs2d, imm;
    logic          src;
    logic [2:0]    ctrl;
    logic [AW-1:0] rs1, rs2, rd;
    logic          rw, mr, mw, m2r;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] a, b, sd;
    logic [2:0]    ctrl;
    logic [AW-1:0] rs1, rs2, rd;
    logic          rw, mr, mw, m2r;
  } out_t;

  typedef struct packed {
    in_t  in;
    logic lus;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic in_t fi(logic v, logic [DW-1:0] rs1d, logic [DW-1:0] rs2d, logic [DW-1:0] imm,
                             logic src, logic [2:0] ctrl, logic [AW-1:0] rs1, logic [AW-1:0] rs2,
                             logic [AW-1:0] rd, logic rw, logic mr, logic mw, logic m2r);
    in_t x;
    x = '{1'b0, 1'b0, v, rs1d, rs2d, imm, src, ctrl, rs1, rs2, rd, rw, mr, mw, m2r};
    return x;
  endfunction

  function automatic out_t fo(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] sd, logic [2:0] ctrl,
                              logic [AW-1:0] rs1, logic [AW-1:0] rs2, logic [AW-1:0] rd,
                              logic rw, logic mr, logic mw, logic m2r);
    out_t y;
    y = '{1'b1, a, b, sd, ctrl, rs1, rs2, rd, rw, mr, mw, m2r};
    return y;
  endfunction

  function automatic in_t with_ctl(in_t x, logic st, logic fl);
    in_t y;
    y = x;
    y.stall = st;
    y.flush = fl;
    return y;
  endfunction

  function automatic out_t get_out();
    out_t y;
    y = '{ex_valid, ex_a, ex_b, ex_store_data, ex_alu_control, ex_rs1, ex_rs2, ex_rd,
          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    return y;
  endfunction

  task automatic drive(input in_t x);
    stall = x.stall; flush = x.flush; id_valid = x.valid;
    id_rs1_data = x.rs1d; id_rs2_data = x.rs2d; id_imm = x.imm;
    id_alu_src = x.src; id_alu_control = x.ctrl;
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
    id_reg_write = x.rw; id_mem_read = x.mr; id_mem_write = x.mw; id_mem_to_reg = x.m2r;
  endtask

  task automatic check_out(input string name, input int idx, input out_t exp);
    out_t got;
    got = get_out();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %h want %h", name, idx, got, exp);
    end
  endtask

  task automatic check_lus(input string name, input int idx, input logic exp);
    n_vec++;
    if (load_use_stall !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: load_use_stall got %b want %b", name, idx, load_use_stall, exp);
    end
  endtask

  task automatic add(input in_t x, input logic lus, input out_t y);
    vec_t v;
    v.in  = x;
    v.lus = lus;
    v.exp = y;
    vecs.push_back(v);
  endtask

  in_t  i_reg, i_imm, i_ld7, i_use7, i_ld0, i_use0, i_ld12, i_inv, i_use12, i_store;
  out_t o_reg, o_imm, o_ld7, o_use7, o_ld0, o_use0, o_ld12, o_use12, o_store;
  out_t bub;

  initial begin
    bub = '0;
    i_reg   = fi(1, 5, 3, 0, 0, 3'b100, 1, 2, 3, 1, 0, 0, 0);
    o_reg   = fo(5, 3, 3, 3'b100, 1, 2, 3, 1, 0, 0, 0);
    i_imm   = fi(1, 'h10, 'hDEAD, 'hFFFF_FFFC, 1, 3'b000, 4, 5, 6, 1, 0, 0, 0);
    o_imm   = fo('h10, 'hFFFF_FFFC, 'hDEAD, 3'b000, 4, 5, 6, 1, 0, 0, 0);
    i_ld7   = fi(1, 'h100, 0, 4, 1, 3'b000, 8, 0, 7, 1, 1, 0, 1);
    o_ld7   = fo('h100, 4, 0, 3'b000, 8, 0, 7, 1, 1, 0, 1);
    i_use7  = fi(1, 1, 2, 'h55, 0, 3'b001, 9, 7, 10, 1, 0, 0, 0);
    o_use7  = fo(1, 2, 2, 3'b001, 9, 7, 10, 1, 0, 0, 0);
    i_ld0   = fi(1, 'h20, 0, 8, 1, 3'b000, 1, 0, 0, 1, 1, 0, 1);
    o_ld0   = fo('h20, 8, 0, 3'b000, 1, 0, 0, 1, 1, 0, 1);
    i_use0  = fi(1, 0, 'h33, 0, 0, 3'b010, 0, 0, 11, 1, 0, 0, 0);
    o_use0  = fo(0, 'h33, 'h33, 3'b010, 0, 0, 11, 1, 0, 0, 0);
    i_ld12  = fi(1, 'h40, 9, 0, 1, 3'b000, 3, 2, 12, 1, 1, 0, 1);
    o_ld12  = fo('h40, 0, 9, 3'b000, 3, 2, 12, 1, 1, 0, 1);
    i_inv   = fi(0, 7, 8, 0, 0, 3'b011, 12, 1, 13, 1, 0, 0, 0);
    i_use12 = fi(1, 7, 8, 0, 0, 3'b011, 12, 1, 13, 1, 0, 0, 0);
    o_use12 = fo(7, 8, 8, 3'b011, 12, 1, 13, 1, 0, 0, 0);
    i_store = fi(1, 'hAA, 'hBB, 'hCC, 1, 3'b000, 14, 15, 0, 0, 0, 1, 0);
    o_store = fo('hAA, 'hCC, 'hBB, 3'b000, 14, 15, 0, 0, 0, 1, 0);

    add(i_reg,   0, o_reg);
    add(i_imm,   0, o_imm);
    add(i_ld7,   0, o_ld7);
    add(i_use7,  1, bub);      // load-use on rs2 -> bubble
    add(i_use7,  0, o_use7);   // ID held, now captured
    add(i_ld0,   0, o_ld0);
    add(i_use0,  0, o_use0);   // load to x0 never stalls
    add(i_ld12,  0, o_ld12);
    add(i_inv,   0, bub);      // invalid ID: no stall, bubble
    add(i_ld12,  0, o_ld12);
    add(i_use12, 1, bub);      // load-use on rs1
    add(i_use12, 0, o_use12);
    add(i_store, 0, o_store);
    add(with_ctl(i_reg, 1, 0), 0, o_store);
    add(with_ctl(i_imm, 1, 0), 0, o_store);
    add(with_ctl(i_ld7, 1, 0), 0, o_store);
    add(with_ctl(i_reg, 1, 1), 0, bub);
    add(i_ld12,  0, o_ld12);
    add(with_ctl(i_use12, 1, 0), 1, o_ld12);  // stall beats load-use bubble
    add(with_ctl(i_use12, 0, 1), 1, bub);
    add(i_reg,   0, o_reg);
    add(with_ctl(i_reg, 0, 1), 0, bub);

    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    drive('0);
    rst_n = 1'b0;
    #2;
    check_out("reset", 0, bub);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      #1;
      check_lus("lus", i, vecs[i].lus);
      @(posedge clk);
      #1;
      check_out("vec", i, vecs[i].exp);
      @(negedge clk);
    end

    // Asynchronous reset with EX full, held across an edge, then release.
    drive(i_reg);
    @(posedge clk); #1;
    check_out("pre_rst", 0, o_reg);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 0, bub);
    @(posedge clk); #1;
    check_out("rst_held", 0, bub);
    @(negedge clk);
    rst_n = 1'b1;
    drive(i_inv);
    @(posedge clk); #1;
    check_out("rel_invalid", 0, bub);
    @(negedge clk);
    drive(i_imm);
    @(posedge clk); #1;
    check_out("rel_load", 0, o_imm);
    @(negedge clk);

`ifdef ID_EX_WB_BYPASS_EN
    wb_reg_write = 1'b1; wb_rd = 4; wb_data = 'h1234;
    drive(fi(1, 0, 'h77, 0, 0, 3'b000, 4, 4, 9, 1, 0, 0, 0));
    @(posedge clk); #1;
    check_out("bypass", 0, fo('h1234, 'h1234, 'h1234, 3'b000, 4, 4, 9, 1, 0, 0, 0));
    @(negedge clk);
    wb_rd = 0;
    drive(fi(1, 0, 'h77, 0, 0, 3'b000, 0, 0, 9, 1, 0, 0, 0));
    @(posedge clk); #1;
    check_out("bypass_x0", 0, fo(0, 'h77, 'h77, 3'b000, 0, 0, 9, 1, 0, 0, 0));
    @(negedge clk);
    wb_reg_write = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register that captures decoded operands and control each cycle and drives the ALU's a, b and alu_control inputs in EX.
- Performs the ALU-source mux (register vs. immediate) at capture time, so the ALU sees final operands straight from flops.
- Detects load-use hazards and inserts a bubble into EX.
- Supports external stall and flush from the hazard/branch unit.

Parameters:
- DATA_W, 32: operand/immediate width; must match the ALU.
- REG_ADDR_W, 5: register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all EX contents
- flush  in  1  replace EX contents with a bubble
- id_valid  in  1  ID holds a real instruction
- id_rs1_data  in  DATA_W  register-file read 1
- id_rs2_data  in  DATA_W  register-file read 2
- id_imm  in  DATA_W  sign-extended immediate
- id_alu_src  in  1  1: b = id_imm; 0: b = rs2 data
- id_alu_control  in  3  ALU op: 000 add, 001 or, 010 and, 011 sll, 100 sub
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- ex_valid  out  1  EX holds a real instruction
- ex_a, ex_b  out  DATA_W  ALU operands
- ex_store_data  out  DATA_W  rs2 data for stores
- ex_alu_control  out  3  to ALU
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered indices
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control bits
- load_use_stall  out  1  combinational; ID/IF must hold this cycle

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, i.e. a bubble.
- Bubble definition: ex_valid, all control bits, ex_alu_control, indices and data outputs are all 0.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & id_valid.
- Per rising edge, first matching rule wins:
  1. flush = 1: load a bubble, including when stall = 1.
  2. stall = 1: hold all outputs unchanged.
  3. load_use_stall = 1: load a bubble; ID is expected to hold, so the same instruction is presented again next cycle.
  4. id_valid = 0: load a bubble.
  5. Otherwise load: ex_valid = 1; ex_a = rs1 data; ex_b = id_alu_src ? id_imm : rs2 data; ex_store_data = rs2 data; copy all indices and control bits.
- Latency: 1 cycle from ID inputs to EX outputs.
- No state machine beyond the pipeline slot; ex_valid is the slot state.
- Index 0: rs1/rs2 data are passed through as given; the register file guarantees x0 = 0. Index 0 never triggers load_use_stall.
- Reset release: the first capture happens on the first edge after rst_n rises.
- Reset asserted mid-operation: the slot clears immediately (asynchronously), independent of clk.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN
- Defined:
  - Adds ports wb_reg_write (in, 1), wb_rd (in, REG_ADDR_W), wb_data (in, DATA_W).
  - On a load, if wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs1), then ex_a takes wb_data.
  - Same rule for id_rs2: wb_data replaces rs2 data for both ex_b (when id_alu_src = 0) and ex_store_data.
  - Covers a same-cycle register-file write and read.
- Not defined: no extra ports; operands are taken only from id_*_data.

Test Plan:
- Reset: rst_n low mid-cycle with EX full -> all outputs 0 immediately; ex_valid stays 0 until the first load after release.
- Register op: rs1_data = 5, rs2_data = 3, alu_src = 0, alu_control = 100 -> next cycle ex_a = 5, ex_b = 3, ex_alu_control = 100, ex_valid = 1.
- Immediate op: rs2_data = 0xDEAD, imm = 0xFFFFFFFC, alu_src = 1 -> ex_b = 0xFFFFFFFC, ex_store_data = 0xDEAD.
- Load-use: EX holds a load with rd = 7; ID has rs2 = 7 -> load_use_stall = 1, next cycle is a bubble. Then with ID held, the instruction loads on the following cycle. Repeating the case with rd = 0 -> no stall.
- Stall and flush: stall = 1 for 3 cycles -> outputs constant. Then stall = 1 and flush = 1 in the same cycle -> bubble.
- Bypass (ID_EX_WB_BYPASS_EN): wb_reg_write = 1, wb_rd = 4, wb_data = 0x1234, id_rs1 = 4, id_rs1_data = 0 -> ex_a = 0x1234. Repeating with wb_rd = 0 -> ex_a = 0.
